// File: rtl/cios_final_sub.sv
// Conditional final subtraction for the CIOS Montgomery multiplier. It streams t and N in,
// computes t - N with a word borrow chain, then streams t mod N out, least significant word first.
`timescale 1ns/1ps
module cios_final_sub #(
    parameter int width = 32,
    parameter int words = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             TTop,
    input  logic             inValid,
    output logic             inReady,
    input  logic [width-1:0] TIn,
    input  logic [width-1:0] NIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [width-1:0] ROut,
    output logic             busy,
    output logic             done
);

    localparam int cw = (words > 1) ? $clog2(words) : 1;
    localparam logic [cw-1:0] last = cw'(words - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DECIDE, EMIT, DONE} state_t;

    state_t           state;
    logic [cw-1:0]    cnt;
    logic [cw-1:0]    cnt_inc;
    logic             borrow;
    logic             ttop_q;
    logic             sel;
    logic             sel_next;
    logic             load_xfer;
    logic [width:0]   diff;
    logic [width-1:0] tbuf [words];
    logic [width-1:0] dbuf [words];

    // The top bit of the (width+1)-bit difference is the borrow into the next word.
    assign diff      = {1'b0, TIn} - {1'b0, NIn} - {{width{1'b0}}, borrow};
    assign load_xfer = (state == LOAD) && inValid && inReady;
    assign sel_next  = ttop_q | ~borrow;
    assign cnt_inc   = cnt + cw'(1);

    // NOTE: the word buffers carry no reset; every entry is written during LOAD before it is read.
    always_ff @(posedge clk) begin
        if (load_xfer) begin
            tbuf[cnt] <= TIn;
            dbuf[cnt] <= diff[width-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inReady  <= 1'b0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ROut     <= '0;
            cnt      <= '0;
            borrow   <= 1'b0;
            ttop_q   <= 1'b0;
            sel      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        ttop_q  <= TTop;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                        inReady <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_xfer) begin
                        borrow <= diff[width];
                        cnt    <= cnt_inc;
                        if (cnt == last) begin
                            inReady <= 1'b0;
                            state   <= DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    // Subtract when t >= N, or when t overflowed into t[s] (final borrow is then moot).
                    sel      <= sel_next;
                    cnt      <= '0;
                    outValid <= 1'b1;
                    ROut     <= sel_next ? dbuf[0] : tbuf[0];
                    state    <= EMIT;
                end
                EMIT: begin
                    if (outReady) begin
                        if (cnt == last) begin
                            outValid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt  <= cnt_inc;
                            ROut <= sel ? dbuf[cnt_inc] : tbuf[cnt_inc];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cios_final_sub.sv
// Bench for cios_final_sub: directed vectors and randomized transactions against an integer model,
// with handshake stalls, reset abort and a single-word instance.
`timescale 1ns/1ps
module tb_cios_final_sub;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TW = W * S;

    logic         clk = 1'b0;
    logic         rst, en, TTop, inValid, inReady, outValid, outReady, busy, done;
    logic [W-1:0] TIn, NIn, ROut;

    logic         en1, TTop1, inValid1, inReady1, outValid1, outReady1, busy1, done1;
    logic [W-1:0] TIn1, NIn1, ROut1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TW-1:0] t;
        logic [TW-1:0] n;
        logic          ttop;
        logic [TW-1:0] r;
    } vec_t;

    vec_t vecs [5];

    cios_final_sub #(.width(W), .words(S)) dut (
        .clk(clk), .rst(rst), .en(en), .TTop(TTop), .inValid(inValid), .inReady(inReady),
        .TIn(TIn), .NIn(NIn), .outValid(outValid), .outReady(outReady), .ROut(ROut),
        .busy(busy), .done(done)
    );

    cios_final_sub #(.width(W), .words(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .TTop(TTop1), .inValid(inValid1), .inReady(inReady1),
        .TIn(TIn1), .NIn(NIn1), .outValid(outValid1), .outReady(outReady1), .ROut(ROut1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Result of the whole stage as one big integer: t mod N given t < 2N (plus the overflow bit).
    function automatic logic [TW-1:0] model(input logic [TW-1:0] t, input logic [TW-1:0] n,
                                            input logic ttop);
        return (ttop || t >= n) ? t - n : t;
    endfunction

    function automatic logic [W-1:0] model1(input logic [W-1:0] t, input logic [W-1:0] n,
                                           input logic ttop);
        return (ttop || t >= n) ? t - n : t;
    endfunction

    task automatic run_txn(input logic [TW-1:0] t, input logic [TW-1:0] n, input logic ttop,
                           input logic [TW-1:0] exp, input bit stall, input string tag);
        int i, j, hold, cyc, lat;
        bit xfer, acc;
        @(negedge clk);
        en   = 1'b1;
        TTop = ttop;
        @(negedge clk);
        en   = 1'b0;
        TTop = ~ttop;
        lat  = 1;
        check({tag, " inReady latency"}, inReady, 1);
        check({tag, " busy"}, busy, 1);
        i   = 0;
        cyc = 0;
        while (i < S && cyc < 200) begin
            inValid = !stall || (cyc % 2 == 0);
            TIn     = t[i*W +: W];
            NIn     = n[i*W +: W];
            if (stall && cyc == 1) en = 1'b1;
            xfer = inValid && inReady;
            @(negedge clk);
            en = 1'b0;
            lat++;
            cyc++;
            if (xfer) i++;
        end
        inValid = 1'b0;
        if (i < S) check({tag, " load timeout"}, i, S);
        j        = 0;
        hold     = 0;
        cyc      = 0;
        outReady = !stall;
        while (j < S && cyc < 200) begin
            if (outValid) begin
                check({tag, " ROut"}, ROut, exp[j*W +: W]);
                if (stall && j == 0 && hold < 3) begin
                    outReady = 1'b0;
                    hold++;
                end else begin
                    outReady = 1'b1;
                end
            end
            acc = outValid && outReady;
            @(negedge clk);
            lat++;
            cyc++;
            if (acc) j++;
        end
        if (j < S) check({tag, " emit timeout"}, j, S);
        check({tag, " done pulse"}, done, 1);
        check({tag, " outValid low"}, outValid, 0);
        if (!stall) check({tag, " latency"}, lat, 2 * S + 2);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle inReady"}, inReady, 0);
    endtask

    task automatic run_one(input logic [W-1:0] t, input logic [W-1:0] n, input logic ttop);
        int cyc;
        @(negedge clk);
        en1       = 1'b1;
        TTop1     = ttop;
        outReady1 = 1'b1;
        @(negedge clk);
        en1      = 1'b0;
        TTop1    = ~ttop;
        inValid1 = 1'b1;
        TIn1     = t;
        NIn1     = n;
        @(negedge clk);
        inValid1 = 1'b0;
        cyc      = 0;
        while (!outValid1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w1 ROut", ROut1, model1(t, n, ttop));
        @(negedge clk);
        check("w1 done", done1, 1);
        @(negedge clk);
        check("w1 idle", busy1, 0);
    endtask

    initial begin
        logic [TW-1:0] t, n;
        logic          tt;
        bit            st;

        vecs[0] = '{16'h0305, 16'h0302, 1'b0, 16'h0003};
        vecs[1] = '{16'h0201, 16'h0302, 1'b0, 16'h0201};
        vecs[2] = '{16'h1234, 16'h1234, 1'b0, 16'h0000};
        vecs[3] = '{16'h0100, 16'h00FF, 1'b0, 16'h0001};
        vecs[4] = '{16'h0001, 16'hFFF0, 1'b1, 16'h0011};

        rst = 1'b1; en = 1'b0; TTop = 1'b0; inValid = 1'b0; outReady = 1'b0;
        TIn = '0; NIn = '0;
        en1 = 1'b0; TTop1 = 1'b0; inValid1 = 1'b0; outReady1 = 1'b0; TIn1 = '0; NIn1 = '0;
        repeat (2) @(negedge clk);
        check("reset inReady", inReady, 0);
        check("reset outValid", outValid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ROut", ROut, 0);
        rst = 1'b0;

        foreach (vecs[k]) run_txn(vecs[k].t, vecs[k].n, vecs[k].ttop, vecs[k].r, 1'b0, "vec");
        foreach (vecs[k]) run_txn(vecs[k].t, vecs[k].n, vecs[k].ttop, vecs[k].r, 1'b1, "vec stall");

        for (int k = 0; k < 40; k++) begin
            t  = TW'($urandom);
            n  = ($urandom_range(0, 3) == 0) ? t + TW'($urandom_range(0, 2)) - TW'(1) : TW'($urandom);
            tt = ($urandom_range(0, 3) == 0);
            st = $urandom_range(0, 1) != 0;
            run_txn(t, n, tt, model(t, n, tt), st, "rand");
        end

        // Leave a nonzero word in ROut, then abort a transaction after its first word.
        run_txn(vecs[1].t, vecs[1].n, vecs[1].ttop, vecs[1].r, 1'b0, "pre-abort");
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en      = 1'b0;
        inValid = 1'b1;
        TIn     = 8'h55;
        NIn     = 8'h11;
        @(negedge clk);
        inValid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort inReady", inReady, 0);
        check("abort outValid", outValid, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort ROut", ROut, 0);
        run_txn(vecs[3].t, vecs[3].n, vecs[3].ttop, vecs[3].r, 1'b0, "post-abort");

        run_one(8'h05, 8'h03, 1'b0);
        run_one(8'h03, 8'h05, 1'b0);
        run_one(8'h7A, 8'h7A, 1'b0);
        run_one(8'h02, 8'hF0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            run_one(W'($urandom), W'($urandom), $urandom_range(0, 1) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cios_final_sub.md
Name: cios_final_sub

Overview:
- Word-serial conditional final subtraction stage of the CIOS Montgomery multiplier. It runs after the outer loop and the alphaf carry/sum add stages have produced the t words.
- Streams in t (LSW first) and modulus N, computes t − N with a word-to-word borrow chain, then streams out R = t mod N.
- Where the alpha add stage propagates a carry upward, this block propagates a borrow. It is the consumer/inverse end of the CIOS word datapath.

Parameters:
- width, 32, word width in bits
- words, 4, number of words per operand (s); valid range ≥1

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  start pulse; sampled only in IDLE
- TTop  input  1  overflow bit t[s] of the Montgomery result; captured on accepted en
- inValid  input  1  TIn/NIn word pair valid
- inReady  output  1  block accepts a word pair
- TIn  input  width  t word, LSW first
- NIn  input  width  modulus word, LSW first
- outValid  output  1  ROut valid
- outReady  input  1  downstream accepts ROut
- ROut  output  width  result word, LSW first
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last result word is accepted

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - state = IDLE; inReady, outValid, busy, done = 0; ROut = 0.
  - Word counter, borrow, TTop latch and select = 0.
  - Reset mid-operation aborts immediately; buffer contents are don't-care afterwards.
- States: IDLE → LOAD → DECIDE → EMIT → DONE → IDLE.
- IDLE:
  - On en = 1: latch TTop, clear borrow and counter, go to LOAD.
  - en in any other state is ignored.
- LOAD:
  - inReady = 1. A transfer occurs when inValid & inReady.
  - Per transfer at index i: {b', D[i]} = TIn − NIn − borrow, computed at width+1 bits. borrow ← b'. Store T[i] = TIn and D[i] into internal buffers. Increment counter.
  - After transfer index words−1, go to DECIDE. inReady drops in the following cycle.
  - No transfer: hold state.
- DECIDE (1 cycle):
  - select ← TTop | ~borrow. This means subtract when t ≥ N or when t overflowed.
  - Clear counter, go to EMIT.
- EMIT:
  - outValid = 1; ROut = select ? D[cnt] : T[cnt].
  - ROut is registered and must be valid in the same cycle outValid rises.
  - ROut and outValid stay stable until outValid & outReady.
  - On each accept, advance cnt. After accepting word words−1, go to DONE with outValid = 0.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Arithmetic:
  - Subtraction is modulo 2^(width·words).
  - When TTop = 1 the final borrow is ignored; the wrapped D is the correct result.
- Latency: with inValid and outReady held high, en → first inReady is 1 cycle. Full transaction = 1 + words + 1 + words + 1 cycles.
- Boundaries:
  - t == N → all-zero result.
  - t < N with TTop = 0 → t passes unchanged.
  - words = 1 must work.
  - inValid stalls mid-LOAD preserve borrow and counter.
  - outReady low holds the current word.
  - en held high during DONE does not retrigger until IDLE.

Test Plan (width = 8, words = 2; values shown MSW:LSW):
- t = 0x0305, N = 0x0302, TTop = 0 → ROut 0x03 then 0x00; done one cycle after second accept.
- t = 0x0201, N = 0x0302, TTop = 0 (borrow out) → t passes: 0x01, 0x02.
- t = N = 0x1234, TTop = 0 → 0x00, 0x00.
- Borrow chain: t = 0x0100, N = 0x00FF → 0x01, 0x00. Overflow case: TTop = 1, t = 0x0001, N = 0xFFF0 → 0x11, 0x00.
- Backpressure: inValid toggled 1/0, outReady low for 3 cycles on word 0 → ROut held stable, same result as with no stalls; en pulsed while busy is ignored.
- rst asserted during LOAD after 1 word → next cycle IDLE with all outputs 0; a fresh transaction afterwards gives the correct result.
